// File: rtl/mem_loader_pkg.sv
// Shared CPU constants: loader FSM encoding and button debounce default.
package mem_loader_pkg;

    // 10 ms at the 100 kHz divided CPU clock.
    localparam int unsigned DebCyclesDefault = 1000;

    typedef enum logic [1:0] {
        StLoadHi = 2'd0,
        StLoadLo = 2'd1,
        StWrite  = 2'd2,
        StRun    = 2'd3
    } ld_state_e;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stable-level debouncer and
// single-cycle press pulse on the debounced rising edge.
module btn_debounce #(
    parameter int unsigned DebCycles = 1000
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CntW = (DebCycles > 1) ? $clog2(DebCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(DebCycles - 1);

    logic            sync1_q, sync2_q;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            level_q, level_d;
    logic            armed_q, armed_d;
    logic            press_q, press_d;

    // Synchronizer is deliberately left out of reset so it already tracks the
    // real pin level when reset is released.
    always_ff @(posedge clk_i) begin
        sync1_q <= btn_i;
        sync2_q <= sync1_q;
    end

    // Count consecutive cycles at the new level; any return to the accepted
    // level restarts the window. A press only counts once the button has been
    // seen released since reset, so a button held through reset stays silent.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        press_d = 1'b0;
        armed_d = armed_q | (~sync2_q & ~level_q);
        if (sync2_q != level_q) begin
            if (cnt_q == CntLast) begin
                level_d = sync2_q;
                press_d = sync2_q & armed_q;
            end else begin
                cnt_d = cnt_q + CntW'(1);
            end
        end
    end

    // Debouncer state with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            armed_q <= 1'b0;
            press_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            armed_q <= armed_d;
            press_q <= press_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/mem_loader.sv
// Front-panel program loader: assembles 16-bit words from two switch bytes,
// writes them to consecutive memory addresses, then releases the CPU.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DebCyclesDefault,
    parameter int unsigned ADDR_W     = 8
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [7:0]        SW,
    input  logic              BTN_LOAD,
    input  logic              BTN_RUN,
    output logic [ADDR_W-1:0] ADDR,
    output logic [15:0]       WDATA,
    output logic              WE,
    output logic              CPU_RST,
    output logic              BUSY,
    output logic              WRAP
);

    ld_state_e         state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              wrap_q, wrap_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              load_ev, run_ev;

    btn_debounce #(
        .DebCycles (DEB_CYCLES)
    ) u_deb_load (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .btn_i   (BTN_LOAD),
        .press_o (load_ev)
    );

    btn_debounce #(
        .DebCycles (DEB_CYCLES)
    ) u_deb_run (
        .clk_i   (CLK),
        .rst_ni  (RST),
        .btn_i   (BTN_RUN),
        .press_o (run_ev)
    );

    // Next-state logic. LOAD wins over RUN in LOAD_HI; RUN is dropped while a
    // word is half entered so partial words are never committed.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wrap_d  = wrap_q;
        unique case (state_q)
            StLoadHi: begin
                if (load_ev) begin
                    wdata_d[15:8] = SW;
                    state_d       = StLoadLo;
                end else if (run_ev) begin
                    state_d = StRun;
                end
            end
            StLoadLo: begin
                if (load_ev) begin
                    wdata_d[7:0] = SW;
                    state_d      = StWrite;
                end
            end
            StWrite: begin
                addr_d  = addr_q + ADDR_W'(1);
                state_d = StLoadHi;
                if (addr_q == '1) begin
                    wrap_d = 1'b1;
                end
            end
            StRun: begin
                state_d = StRun;
            end
            default: begin
                state_d = StLoadHi;
            end
        endcase
        cpu_rst_d = (state_d == StRun);
    end

    // Loader state registers with synchronous active-low reset.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q   <= StLoadHi;
            addr_q    <= '0;
            wdata_q   <= '0;
            wrap_q    <= 1'b0;
            cpu_rst_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            wrap_q    <= wrap_d;
            cpu_rst_q <= cpu_rst_d;
        end
    end

    // Strobe is gated by RST so a reset landing on the WRITE cycle kills it.
    always_comb begin
        WE   = (state_q == StWrite) && RST;
        BUSY = (state_q != StRun);
    end

    assign ADDR    = addr_q;
    assign WDATA   = wdata_q;
    assign WRAP    = wrap_q;
    assign CPU_RST = cpu_rst_q;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader with DEB_CYCLES=4.
module tb_mem_loader;

    localparam int unsigned Deb  = 4;
    localparam int unsigned Hold = Deb + 6;

    logic        clk;
    logic        rst;
    logic [7:0]  sw;
    logic        btn_load;
    logic        btn_run;
    logic [7:0]  addr;
    logic [15:0] wdata;
    logic        we;
    logic        cpu_rst;
    logic        busy;
    logic        wrap;

    int checks   = 0;
    int failures = 0;

    logic [23:0] exp_q[$];

    mem_loader #(
        .DEB_CYCLES (Deb),
        .ADDR_W     (8)
    ) dut (
        .CLK      (clk),
        .RST      (rst),
        .SW       (sw),
        .BTN_LOAD (btn_load),
        .BTN_RUN  (btn_run),
        .ADDR     (addr),
        .WDATA    (wdata),
        .WE       (we),
        .CPU_RST  (cpu_rst),
        .BUSY     (busy),
        .WRAP     (wrap)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe must match the next queued write.
    always @(negedge clk) begin
        if (we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_we: got addr=0x%0h wdata=0x%0h expected no write",
                         addr, wdata);
            end else begin
                logic [23:0] e;
                e = exp_q.pop_front();
                chk("write", {addr, wdata}, {8'h0, e});
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press_load(input logic [7:0] val);
        sw = val;
        btn_load = 1'b1;
        cyc(Hold);
        btn_load = 1'b0;
        cyc(Hold);
    endtask

    task automatic press_run();
        btn_run = 1'b1;
        cyc(Hold);
        btn_run = 1'b0;
        cyc(Hold);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        cyc(2);
        rst = 1'b1;
        cyc(1);
    endtask

    initial begin
        int to;
        rst = 1'b0;
        sw = 8'h00;
        btn_load = 1'b0;
        btn_run = 1'b0;
        cyc(3);

        // Reset state.
        @(negedge clk);
        chk("rst_addr", 32'(addr), 32'h0);
        chk("rst_wdata", 32'(wdata), 32'h0);
        chk("rst_we", 32'(we), 32'h0);
        chk("rst_cpu_rst", 32'(cpu_rst), 32'h0);
        chk("rst_busy", 32'(busy), 32'h1);
        chk("rst_wrap", 32'(wrap), 32'h0);
        rst = 1'b1;
        cyc(2);

        // Basic word 0x1234 at address 0.
        exp_q.push_back({8'h00, 16'h1234});
        press_load(8'h12);
        @(negedge clk);
        chk("hi_byte", 32'(wdata), 32'h1200);
        press_load(8'h34);
        @(negedge clk);
        chk("addr_after_1", 32'(addr), 32'h1);
        chk("wdata_after_1", 32'(wdata), 32'h1234);

        // Three-cycle glitch: no event.
        sw = 8'hFF;
        btn_load = 1'b1;
        cyc(3);
        btn_load = 1'b0;
        cyc(Hold);
        @(negedge clk);
        chk("glitch_wdata", 32'(wdata), 32'h1234);
        chk("glitch_addr", 32'(addr), 32'h1);

        // RUN ignored mid-word, honoured in LOAD_HI.
        exp_q.push_back({8'h01, 16'h5678});
        press_load(8'h56);
        press_run();
        @(negedge clk);
        chk("midword_busy", 32'(busy), 32'h1);
        chk("midword_cpu_rst", 32'(cpu_rst), 32'h0);
        press_load(8'h78);
        @(negedge clk);
        chk("addr_after_2", 32'(addr), 32'h2);
        press_run();
        @(negedge clk);
        chk("run_cpu_rst", 32'(cpu_rst), 32'h1);
        chk("run_busy", 32'(busy), 32'h0);
        press_load(8'hAA);
        press_load(8'hBB);
        @(negedge clk);
        chk("run_hold_addr", 32'(addr), 32'h2);
        chk("run_hold_wdata", 32'(wdata), 32'h5678);
        chk("run_still_cpu_rst", 32'(cpu_rst), 32'h1);

        // Reset during RUN.
        rst = 1'b0;
        cyc(1);
        @(negedge clk);
        chk("rstrun_cpu_rst", 32'(cpu_rst), 32'h0);
        chk("rstrun_addr", 32'(addr), 32'h0);
        chk("rstrun_busy", 32'(busy), 32'h1);
        chk("rstrun_we", 32'(we), 32'h0);
        rst = 1'b1;
        cyc(2);

        // LOAD and RUN together in LOAD_HI: LOAD wins.
        sw = 8'h9A;
        btn_load = 1'b1;
        btn_run = 1'b1;
        cyc(Hold);
        btn_load = 1'b0;
        btn_run = 1'b0;
        cyc(Hold);
        @(negedge clk);
        chk("both_wdata", 32'(wdata), 32'h9A00);
        chk("both_cpu_rst", 32'(cpu_rst), 32'h0);
        chk("both_busy", 32'(busy), 32'h1);
        exp_q.push_back({8'h00, 16'h9ABC});
        press_load(8'hBC);
        @(negedge clk);
        chk("both_addr", 32'(addr), 32'h1);

        // Reset landing on the WRITE cycle; LOAD held through reset release.
        press_load(8'h11);
        sw = 8'h22;
        btn_load = 1'b1;
        to = 0;
        while (we !== 1'b1 && to < 40) begin
            cyc(1);
            to++;
        end
        chk("write_seen_timeout", 32'(to < 40), 32'h1);
        rst = 1'b0;
        #1;
        chk("rstwr_we_now", 32'(we), 32'h0);
        cyc(1);
        @(negedge clk);
        chk("rstwr_we", 32'(we), 32'h0);
        chk("rstwr_addr", 32'(addr), 32'h0);
        chk("rstwr_cpu_rst", 32'(cpu_rst), 32'h0);
        sw = 8'hEE;
        rst = 1'b1;
        cyc(3 * Hold);
        @(negedge clk);
        chk("held_no_event", 32'(wdata), 32'h0);
        btn_load = 1'b0;
        cyc(Hold);
        exp_q.push_back({8'h00, 16'h2233});
        press_load(8'h22);
        press_load(8'h33);
        @(negedge clk);
        chk("after_held_addr", 32'(addr), 32'h1);

        // 256 words from a fresh reset: wrap.
        do_reset();
        for (int i = 0; i < 256; i++) begin
            logic [7:0] b;
            b = 8'(i);
            exp_q.push_back({b, b, ~b});
            if (i == 255) begin
                @(negedge clk);
                chk("pre_wrap_flag", 32'(wrap), 32'h0);
                chk("pre_wrap_addr", 32'(addr), 32'hFF);
            end
            press_load(b);
            press_load(~b);
        end
        @(negedge clk);
        chk("wrap_addr", 32'(addr), 32'h0);
        chk("wrap_flag", 32'(wrap), 32'h1);
        exp_q.push_back({8'h00, 16'hC0DE});
        press_load(8'hC0);
        press_load(8'hDE);
        @(negedge clk);
        chk("wrap_sticky", 32'(wrap), 32'h1);
        chk("addr_after_wrap", 32'(addr), 32'h1);

        cyc(4);
        chk("queue_drained", 32'(exp_q.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
MEM_LOADER -- requirements
Module: mem_loader

Interface
REQ-001 Parameter DEB_CYCLES, default 1000, consecutive stable cycles required to accept a button level (10 ms at the 100 kHz CPU clock).
REQ-002 Parameter ADDR_W, default 8, memory address width.
REQ-003 CLK  input  1  single clock, the divided CPU clock; all state updates on rising edge.
REQ-004 RST  input  1  synchronous, active-low reset, sampled on rising CLK.
REQ-005 SW  input  8  raw slide-switch data byte.
REQ-006 BTN_LOAD  input  1  raw, asynchronous push-button; a press captures one byte.
REQ-007 BTN_RUN  input  1  raw, asynchronous push-button; a press ends loading and releases the CPU.
REQ-008 ADDR  output  ADDR_W  memory write address.
REQ-009 WDATA  output  16  memory write word, {high byte, low byte}.
REQ-010 WE  output  1  one-cycle memory write strobe.
REQ-011 CPU_RST  output  1  active-low reset to the CPU datapath and control unit; low while loading.
REQ-012 BUSY  output  1  high in every state except RUN.
REQ-013 WRAP  output  1  sticky flag; set when ADDR wraps from all-ones to 0.

Function
REQ-014 Each button passes through a 2-flop synchronizer, then a debouncer that changes its output only after DEB_CYCLES consecutive cycles at the new level.
REQ-015 A press event is a single-cycle pulse on the debounced 0->1 transition; release generates no event.
REQ-016 FSM states: LOAD_HI, LOAD_LO, WRITE, RUN.
REQ-017 LOAD_HI: a LOAD event latches SW into WDATA[15:8] and moves to LOAD_LO.
REQ-018 LOAD_LO: a LOAD event latches SW into WDATA[7:0] and moves to WRITE.
REQ-019 WRITE lasts exactly one cycle: WE=1 with the current ADDR and WDATA; the next cycle ADDR increments by 1 and the state returns to LOAD_HI.
REQ-020 WE SHALL be 0 in every state other than WRITE.
REQ-021 At ADDR all-ones, the increment wraps to 0 and sets WRAP; WRAP holds until reset.
REQ-022 A RUN event in LOAD_HI moves to RUN; CPU_RST goes high on the following cycle.
REQ-023 A RUN event in LOAD_LO or WRITE is discarded, so a half-entered word is never committed.
REQ-024 If LOAD and RUN events occur in the same cycle in LOAD_HI, LOAD is taken and RUN is discarded.
REQ-025 In RUN, all button events are ignored, WE=0, CPU_RST=1, and ADDR/WDATA hold; only RST leaves RUN.
REQ-026 Button activity during a debounce window restarts that window; a glitch shorter than DEB_CYCLES generates no event.

Reset
REQ-027 On RST=0 at a rising edge: state=LOAD_HI, ADDR=0, WDATA=0, WE=0, CPU_RST=0, BUSY=1, WRAP=0, debouncer counters=0, debounced levels=0.
REQ-028 Reset mid-WRITE suppresses that write: WE=0 from the reset cycle onward.
REQ-029 A button held through reset release generates no event until it is released and pressed again.

Structure
REQ-030 The state encoding and the DEB_CYCLES default value SHALL reside in the shared CPU constants package used by the control unit.
REQ-031 A sub-module btn_debounce (synchronizer + counter + edge pulse) SHALL be instantiated once per button.
REQ-032 mem_loader sits upstream of main memory; main memory write-port selection between the loader and MBR uses BUSY.

Verification (bench uses DEB_CYCLES=4)
REQ-033 SW=0x12 LOAD press, SW=0x34 LOAD press -> one WE pulse with ADDR=0 and WDATA=0x1234, then ADDR=1 and state LOAD_HI.
REQ-034 3-cycle LOAD glitch -> no event, WDATA unchanged, no WE.
REQ-035 One byte entered, then RUN press -> RUN ignored, BUSY=1, CPU_RST=0; second byte -> write occurs; RUN press -> CPU_RST=1, BUSY=0.
REQ-036 256 words loaded -> the 256th write is at ADDR=0xFF, then ADDR=0x00 and WRAP=1.
REQ-037 LOAD and RUN debounced in the same cycle in LOAD_HI -> high byte latched, state LOAD_LO, CPU_RST stays 0.
REQ-038 RST=0 during the WRITE cycle and during RUN -> WE=0, ADDR=0, CPU_RST=0, state LOAD_HI on the next edge.
